// File: rtl/pingpong_block_interleaver_if.sv
// Sample stream bundle for the ping-pong block interleaver.
// The master drives the input side and the slave (the interleaver) drives the output side.
interface pingpong_block_interleaver_if #(parameter int W = 1);
  logic         mode_i;
  logic         in_valid;
  logic         in_sof;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_sof;
  logic [W-1:0] out_data;
  logic         err_o;

  modport master (
    output mode_i, in_valid, in_sof, in_data,
    input  out_valid, out_sof, out_data, err_o
  );

  modport slave (
    input  mode_i, in_valid, in_sof, in_data,
    output out_valid, out_sof, out_data, err_o
  );
endinterface

// File: rtl/pingpong_block_interleaver.sv
// Two-bank row/column block interleaver and deinterleaver.
// One bank is written row-wise while the other is read in permuted order; the roles swap every ROWS*COLS samples.
module pingpong_block_interleaver #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int W    = 1
) (
  input logic clk,
  input logic rst,
  pingpong_block_interleaver_if.slave bus
);
  localparam int N  = ROWS * COLS;
  localparam int KW = $clog2(N);

  logic [W-1:0]  r_mem [2][N];
  logic          r_mode [2];
  logic          r_wr_bank;
  logic [KW-1:0] r_k;
  logic          r_primed;
  logic          r_out_valid;
  logic          r_out_sof;
  logic [W-1:0]  r_out_data;
  logic          r_err;

  logic          w_realign;
  logic [KW-1:0] w_wr_k;
  logic [KW-1:0] w_perm_il;
  logic [KW-1:0] w_perm_dl;
  logic [KW-1:0] w_perm;

  // An in_sof in the middle of a block restarts the current bank at k=0.
  assign w_realign = bus.in_valid & bus.in_sof & (r_k != '0);
  assign w_wr_k    = w_realign ? '0 : r_k;

  assign w_perm_il = KW'((int'(r_k) % ROWS) * COLS + int'(r_k) / ROWS);
  assign w_perm_dl = KW'((int'(r_k) % COLS) * ROWS + int'(r_k) / COLS);
  // The read bank's permutation follows the mode captured when that bank was filled.
  assign w_perm    = r_mode[~r_wr_bank] ? w_perm_dl : w_perm_il;

  always_ff @(posedge clk) begin
    if (bus.in_valid) begin
      r_mem[r_wr_bank][w_wr_k] <= bus.in_data;
      if (w_wr_k == '0)
        r_mode[r_wr_bank] <= bus.mode_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_bank   <= 1'b0;
      r_k         <= '0;
      r_primed    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sof   <= 1'b0;
      r_out_data  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_out_sof   <= 1'b0;
      r_err       <= 1'b0;
      if (bus.in_valid) begin
        if (w_realign) begin
          r_primed <= 1'b0;
          r_err    <= 1'b1;
          r_k      <= KW'(1);
        end else begin
          if (r_primed) begin
            r_out_valid <= 1'b1;
            r_out_sof   <= (r_k == '0);
            r_out_data  <= r_mem[~r_wr_bank][w_perm];
          end
          if (r_k == KW'(N - 1)) begin
            r_k       <= '0;
            r_wr_bank <= ~r_wr_bank;
            r_primed  <= 1'b1;
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_sof   = r_out_sof;
  assign bus.out_data  = r_out_data;
  assign bus.err_o     = r_err;
endmodule

// File: tb/tb_pingpong_block_interleaver.sv
// Bench for pingpong_block_interleaver: a 4x4 instance, a 2x3 instance and a 3x5 interleave->deinterleave chain,
// each checked against a block-level reference model.
module tb_pingpong_block_interleaver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_a = 1'b1;
  always #5 clk = ~clk;

  pingpong_block_interleaver_if #(.W(8)) ia ();
  pingpong_block_interleaver_if #(.W(4)) ib ();
  pingpong_block_interleaver_if #(.W(8)) ic1 ();
  pingpong_block_interleaver_if #(.W(8)) ic2 ();

  pingpong_block_interleaver #(.ROWS(4), .COLS(4), .W(8)) u_a (.clk(clk), .rst(rst_a), .bus(ia.slave));
  pingpong_block_interleaver #(.ROWS(2), .COLS(3), .W(4)) u_b (.clk(clk), .rst(rst), .bus(ib.slave));
  pingpong_block_interleaver #(.ROWS(3), .COLS(5), .W(8)) u_c1 (.clk(clk), .rst(rst), .bus(ic1.slave));
  pingpong_block_interleaver #(.ROWS(3), .COLS(5), .W(8)) u_c2 (.clk(clk), .rst(rst), .bus(ic2.slave));

  assign ic2.in_valid = ic1.out_valid;
  assign ic2.in_sof   = ic1.out_sof;
  assign ic2.in_data  = ic1.out_data;
  assign ic2.mode_i   = 1'b1;

  int total = 0;
  int bad   = 0;

  // Reference model, indexed by instance (0 = 4x4, 1 = 2x3): the block being
  // filled and the expected output order of the previous full block.
  int m_cur  [2][16];
  int m_cn   [2];
  int m_exp  [2][16];
  int m_en   [2];
  int m_er   [2];
  bit m_mode [2];
  int m_last [2];

  int chain_q[$];
  int chain_n = 0;

  function automatic int rows_of(input int id);
    return (id == 0) ? 4 : 2;
  endfunction

  function automatic int cols_of(input int id);
    return (id == 0) ? 4 : 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear(input int id);
    m_cn[id] = 0; m_en[id] = 0; m_er[id] = 0; m_last[id] = 0; m_mode[id] = 1'b0;
  endtask

  // Interleave reads the R x C matrix column by column; deinterleave reads it
  // as if it had been written column-wise, i.e. the transpose.
  task automatic model_finish_block(input int id);
    int r, c, idx;
    r = rows_of(id); c = cols_of(id); idx = 0;
    if (!m_mode[id]) begin
      for (int cc = 0; cc < c; cc++)
        for (int rr = 0; rr < r; rr++) begin
          m_exp[id][idx] = m_cur[id][rr * c + cc]; idx++;
        end
    end else begin
      for (int rr = 0; rr < r; rr++)
        for (int cc = 0; cc < c; cc++) begin
          m_exp[id][idx] = m_cur[id][cc * r + rr]; idx++;
        end
    end
    m_en[id] = r * c; m_er[id] = 0; m_cn[id] = 0;
  endtask

  task automatic step(input int id, input bit v, input bit sof, input bit md, input int d);
    logic ov, os, oe;
    logic [31:0] od;
    bit ex_v, ex_s, ex_e;
    string pre;
    pre = (id == 0) ? "A" : "B";
    if (id == 0) begin
      ia.in_valid = v; ia.in_sof = sof; ia.mode_i = md; ia.in_data = 8'(d);
    end else begin
      ib.in_valid = v; ib.in_sof = sof; ib.mode_i = md; ib.in_data = 4'(d);
    end
    @(posedge clk); #1;
    if (id == 0) begin
      ov = ia.out_valid; os = ia.out_sof; oe = ia.err_o; od = 32'(ia.out_data);
      ia.in_valid = 1'b0; ia.in_sof = 1'b0;
    end else begin
      ov = ib.out_valid; os = ib.out_sof; oe = ib.err_o; od = 32'(ib.out_data);
      ib.in_valid = 1'b0; ib.in_sof = 1'b0;
    end
    ex_v = 1'b0; ex_s = 1'b0; ex_e = 1'b0;
    if (v) begin
      if (sof && m_cn[id] != 0) begin
        ex_e = 1'b1; m_cn[id] = 0; m_en[id] = 0;
      end else if (m_en[id] != 0) begin
        ex_v = 1'b1; ex_s = (m_er[id] == 0);
        m_last[id] = m_exp[id][m_er[id]]; m_er[id]++;
      end
      if (m_cn[id] == 0) m_mode[id] = md;
      m_cur[id][m_cn[id]] = d; m_cn[id]++;
      if (m_cn[id] == rows_of(id) * cols_of(id)) model_finish_block(id);
    end
    chk({pre, "_valid"}, 32'(ov), 32'(ex_v));
    chk({pre, "_sof"},   32'(os), 32'(ex_s));
    chk({pre, "_err"},   32'(oe), 32'(ex_e));
    chk({pre, "_data"},  od, m_last[id]);
  endtask

  task automatic reset_a();
    #2 rst_a = 1'b1;
    #2;
    chk("A_rst_valid", 32'(ia.out_valid), 0);
    chk("A_rst_sof",   32'(ia.out_sof), 0);
    chk("A_rst_err",   32'(ia.err_o), 0);
    chk("A_rst_data",  32'(ia.out_data), 0);
    @(posedge clk); #1;
    rst_a = 1'b0;
    model_clear(0);
  endtask

  task automatic chain_cyc(input bit v, input bit sof, input int d);
    int e;
    ic1.in_valid = v; ic1.in_sof = sof; ic1.in_data = 8'(d);
    if (v) chain_q.push_back(d);
    @(posedge clk); #1;
    ic1.in_valid = 1'b0; ic1.in_sof = 1'b0;
    if (ic2.out_valid) begin
      chk("chain_not_extra", 32'(chain_q.size() != 0), 1);
      if (chain_q.size() != 0) begin
        e = chain_q.pop_front();
        chk("chain_data", 32'(ic2.out_data), e);
        chk("chain_sof", 32'(ic2.out_sof), 32'(chain_n % 15 == 0));
        chain_n++;
      end
    end
    chk("chain_err", 32'(ic1.err_o | ic2.err_o), 0);
  endtask

  initial begin
    bit bm;
    ia.in_valid = 0; ia.in_sof = 0; ia.mode_i = 0; ia.in_data = '0;
    ib.in_valid = 0; ib.in_sof = 0; ib.mode_i = 0; ib.in_data = '0;
    ic1.in_valid = 0; ic1.in_sof = 0; ic1.mode_i = 0; ic1.in_data = '0;
    model_clear(0); model_clear(1);
    repeat (2) @(posedge clk);
    #1;
    chk("A_reset_valid", 32'(ia.out_valid), 0);
    chk("A_reset_sof",   32'(ia.out_sof), 0);
    chk("A_reset_err",   32'(ia.err_o), 0);
    chk("A_reset_data",  32'(ia.out_data), 0);
    rst_a = 1'b0; rst = 1'b0;

    // 4x4 interleave of 0..31, continuous
    for (int i = 0; i < 32; i++) step(0, 1'b1, (i % 16) == 0, 1'b0, i);

    // mode_i rises at k=7 of a mode-0 block; the following block is deinterleaved
    for (int i = 0; i < 16; i++) step(0, 1'b1, i == 0, i >= 7, 100 + i);
    for (int i = 0; i < 16; i++) step(0, 1'b1, i == 0, 1'b1, 140 + i);
    for (int i = 0; i < 16; i++) step(0, 1'b1, i == 0, 1'b0, 180 + i);

    // random blocks, random gaps, noise on mode_i away from k=0
    for (int b = 0; b < 5; b++) begin
      bm = 1'($urandom_range(0, 1));
      for (int i = 0; i < 16; i++) begin
        while ($urandom_range(0, 3) == 0) step(0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 0);
        step(0, 1'b1, i == 0, (i == 0) ? bm : 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
      end
    end

    // in_sof at k=5 while primed, then a full block and its readout
    for (int i = 0; i < 5; i++) step(0, 1'b1, i == 0, 1'b0, 20 + i);
    step(0, 1'b1, 1'b1, 1'b0, 50);
    for (int i = 1; i < 16; i++) step(0, 1'b1, 1'b0, 1'b0, 50 + i);
    for (int i = 0; i < 16; i++) step(0, 1'b1, i == 0, 1'b0, 70 + i);

    // reset at k=9 while primed
    for (int i = 0; i < 9; i++) step(0, 1'b1, i == 0, 1'b0, 90 + i);
    reset_a();
    for (int i = 0; i < 32; i++) step(0, 1'b1, (i % 16) == 0, 1'b0, 200 + (i % 50));

    // 2x3, W=4: mode 0 on 0..5, then mode 1 on 0,3,1,4,2,5, then filler
    for (int i = 0; i < 6; i++) step(1, 1'b1, i == 0, 1'b0, i);
    step(1, 1'b1, 1'b1, 1'b1, 0); step(1, 1'b1, 1'b0, 1'b1, 3); step(1, 1'b1, 1'b0, 1'b1, 1);
    step(1, 1'b1, 1'b0, 1'b1, 4); step(1, 1'b1, 1'b0, 1'b1, 2); step(1, 1'b1, 1'b0, 1'b1, 5);
    for (int i = 0; i < 6; i++) step(1, 1'b1, i == 0, 1'b0, 9);

    // 3x5 interleave -> deinterleave chain, 10 random blocks with gaps
    for (int b = 0; b < 10; b++)
      for (int i = 0; i < 15; i++) begin
        while ($urandom_range(0, 2) == 0) chain_cyc(1'b0, 1'b0, 0);
        chain_cyc(1'b1, i == 0, int'($urandom_range(0, 255)));
      end
    repeat (5) chain_cyc(1'b0, 1'b0, 0);
    chk("chain_count", chain_n, 120);
    chk("chain_left", chain_q.size(), 30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pingpong_block_interleaver.md
# pingpong_block_interleaver

Parametrised row/column block interleaver and deinterleaver for the channel-coding path. Samples are written row-wise into one of two RAM banks while the other bank is read in permuted order. The bank roles swap every N = ROWS*COLS accepted samples. A per-block mode bit selects interleave or its exact inverse, so one block serves both the transmit and receive chains.

## Interface
- ROWS, default 4: matrix rows; must be ≥ 1.
- COLS, default 4: matrix columns; must be ≥ 1, and ROWS*COLS ≥ 2.
- W, default 1: sample width in bits (1 for hard bits, >1 for soft values).
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- mode_i  in  1  0 = interleave, 1 = deinterleave; sampled only with the first sample of a block.
- in_valid  in  1  sample strobe; the block advances only on cycles with in_valid=1.
- in_sof  in  1  start-of-frame, qualified by in_valid.
- in_data  in  W  input sample.
- out_valid  out  1  output sample strobe.
- out_sof  out  1  high with the first output sample of each block.
- out_data  out  W  output sample.
- err_o  out  1  one-cycle pulse when a partial block is dropped.

## Operation
- Storage: two banks of N words × W bits, each with a stored mode bit. Banks are not cleared by reset.
- State:
  - wr_bank (1 bit);
  - index k, range 0..N-1, width clog2(N);
  - primed flag.
- Each accepted sample (in_valid=1):
  - write in_data to bank[wr_bank][k];
  - if primed, read bank[!wr_bank][perm(k)] into the output register.
- Permutation, integer arithmetic, k < N:
  - interleave: perm(k) = (k % ROWS)*COLS + k / ROWS. This writes row-wise and reads column-wise.
  - deinterleave: perm(k) = (k % COLS)*ROWS + k / COLS. This is the exact inverse for the same ROWS/COLS.
- Mode latching: at k=0, mode_i is stored with wr_bank. A bank's read permutation uses the mode stored when that bank was written, not the live mode_i.
- Wrap-around: at k=N-1, k returns to 0, wr_bank toggles, and primed is set. There is no idle cycle between blocks, unlike a 15+1 counter scheme.
- Frame alignment, in_valid=1 and in_sof=1:
  - at k=0: normal accept.
  - at k≠0: the partial block is discarded. Clear primed, pulse err_o, and write the sample as k=0 of the current wr_bank (no toggle). Latch mode_i.
- in_valid=0: nothing changes. out_valid=0 and out_data holds its value.

## Timing
- Reset values: out_valid=0, out_sof=0, out_data=0, err_o=0, k=0, wr_bank=0, primed=0.
- Output is registered. An accepted sample at edge t gives out_valid=1 at edge t+1, only when primed was 1 before edge t.
- Latency is N accepted samples plus 1 clock. Sample j of block b appears during block b+1, at the position whose k satisfies perm(k)=j.
- out_sof=1 exactly when out_valid=1 and the read index was k=0.
- The first block after reset or after an in_sof realignment produces no output.
- Throughput is one sample per clock sustained. Gaps in in_valid stall the read and write sides identically.
- err_o is asserted in the cycle after the offending in_sof sample.
- Reset mid-block: all state returns to reset values. The next sample is k=0, and output resumes only after a full new block.

## Test plan
- ROWS=4, COLS=4, mode 0, inputs 0..31 continuous:
  - no out_valid for the first 16 samples;
  - then out_data = 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15;
  - out_sof on the first of these.
- ROWS=2, COLS=3, W=4:
  - mode 0, inputs 0..5 then filler → output 0,3,1,4,2,5;
  - mode 1, inputs 0,3,1,4,2,5 → output 0,1,2,3,4,5.
- Interleave then deinterleave chain, ROWS=3, COLS=5, W=8, 10 random blocks with random in_valid gaps:
  - output equals input delayed by 2 blocks;
  - no extra or missing out_valid.
- Mode change mid-block: drive mode_i=1 from k=7 of a mode-0 block → that block still reads out interleaved; the next block reads deinterleaved.
- in_sof at k=5 while primed:
  - err_o pulses once;
  - out_valid drops for the following 16 samples;
  - the new block then reads out correctly.
- Assert rst for 1 cycle at k=9 while primed → all outputs read 0 after the reset edge; no output during the next N samples.
